sram_1w1r_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that drives a 1-write/1-read OpenRAM macro (default `freepdk45_sram_1w1r_31x128`) as its storage. It is the initiator for both SRAM ports: it issues writes on port 0 for accepted pushes and reads on port 1 to prefetch into a 2-entry output buffer. It hides the one-cycle SRAM read latency so pops sustain one word per cycle. It sits between a valid/ready producer and consumer, with the macro instantiated alongside it.

---
 rtl/sram_fifo_pkg.sv | 16 +
 rtl/sram_fifo_obuf.sv | 50 +++++
 rtl/sram_1w1r_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_sram_1w1r_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed FIFO controller,
// sized for the freepdk45_sram_1w1r_31x128 OpenRAM macro.
package sram_fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 128;
   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DEPTH      = 31;

   typedef logic [DEF_ADDR_WIDTH:0] level_t;

   // Depth is not a power of two, so the pointer wrap must be explicit.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output skid buffer that absorbs the SRAM read latency so the
// consumer can pop one word per cycle.
module sram_fifo_obuf
   import sram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  capture_i,
   input  logic [DATA_WIDTH-1:0] cap_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic [1:0]            ob_cnt_o
);

   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic [1:0]            cnt_q;

   // The read-issue rule upstream guarantees a capture never arrives while full.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (capture_i && pop_i) begin
         if (cnt_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= cap_data_i;
         end else begin
            head_q <= cap_data_i;
         end
      end else if (capture_i) begin
         if (cnt_q == 2'd0) begin
            head_q <= cap_data_i;
         end else begin
            tail_q <= cap_data_i;
         end
         cnt_q <= cnt_q + 2'd1;
      end else if (pop_i) begin
         head_q <= tail_q;
         cnt_q  <= cnt_q - 2'd1;
      end
   end

   assign head_o   = head_q;
   assign ob_cnt_o = cnt_q;

endmodule

// File: rtl/sram_1w1r_fifo_ctrl.sv
// FIFO controller driving a 1-write/1-read OpenRAM macro: writes on port 0,
// prefetches on port 1 into a 2-entry output buffer.
module sram_1w1r_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
   logic                  inflight_q;
   logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
   logic [DATA_WIDTH-1:0] din0_q;

   logic       push_fire;
   logic       pop_fire;
   logic       rd_issue;
   logic [1:0] ob_cnt;
   logic [2:0] ob_pending;

   // Readiness comes from registered state only, so a full SRAM blocks pushes
   // even when a read frees a word in the same cycle.
   assign push_ready = rstb & (mem_cnt_q < DEPTH_C);
   assign push_fire  = push_valid & push_ready;
   assign pop_valid  = (ob_cnt != 2'd0);
   assign pop_fire   = pop_valid & pop_ready;

   assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight_q} - {2'b00, pop_fire};
   assign rd_issue   = rstb & (mem_cnt_q != '0) & (ob_pending < 3'd2);

   assign sram_csb0  = ~push_fire;
   assign sram_addr0 = push_fire ? wr_ptr_q : addr0_q;
   assign sram_din0  = push_fire ? push_data : din0_q;
   assign sram_csb1  = ~rd_issue;
   assign sram_addr1 = rd_issue ? rd_ptr_q : addr1_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      mem_cnt_d = mem_cnt_q + (ADDR_WIDTH + 1)'(push_fire) - (ADDR_WIDTH + 1)'(rd_issue);
      if (push_fire) begin
         wr_ptr_d = ADDR_WIDTH'(ptr_inc(int'(wr_ptr_q), DEPTH));
      end
      if (rd_issue) begin
         rd_ptr_d = ADDR_WIDTH'(ptr_inc(int'(rd_ptr_q), DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_cnt_q  <= '0;
         inflight_q <= 1'b0;
         addr0_q    <= '0;
         addr1_q    <= '0;
         din0_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_cnt_q  <= mem_cnt_d;
         inflight_q <= rd_issue;
         addr0_q    <= sram_addr0;
         addr1_q    <= sram_addr1;
         din0_q     <= sram_din0;
      end
   end

   // Read data is only valid on the edge after the read, tagged by inflight_q.
   sram_fifo_obuf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_obuf (
      .clk        (clk),
      .rstb       (rstb),
      .capture_i  (inflight_q),
      .cap_data_i (sram_dout1),
      .pop_i      (pop_fire),
      .head_o     (pop_data),
      .ob_cnt_o   (ob_cnt)
   );

   assign level = mem_cnt_q + (ADDR_WIDTH + 1)'(inflight_q) + (ADDR_WIDTH + 1)'(ob_cnt);

endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// Randomized and directed bench for the SRAM FIFO controller, checked
// against a queue-based model of FIFO contents and sequential addressing.
module tb_sram_1w1r_fifo_ctrl;
   import sram_fifo_pkg::*;

   localparam int DW    = 128;
   localparam int AW    = 5;
   localparam int DEPTH = 31;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          push_valid = 1'b0;
   logic          push_ready;
   logic [DW-1:0] push_data = '0;
   logic          pop_valid;
   logic          pop_ready = 1'b0;
   logic [DW-1:0] pop_data;
   logic [AW:0]   level;
   logic          sram_csb0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic          sram_csb1;
   logic [AW-1:0] sram_addr1;
   logic [DW-1:0] sram_dout1 = '0;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] q[$];
   int            total = 0;
   int            bad = 0;
   int            wrCnt = 0;
   int            rdCnt = 0;

   always #5 clk = ~clk;

   sram_1w1r_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_data  (push_data),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .pop_data   (pop_data),
      .level      (level),
      .sram_csb0  (sram_csb0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_csb1  (sram_csb1),
      .sram_addr1 (sram_addr1),
      .sram_dout1 (sram_dout1)
   );

   // Macro model: read data lives on dout1 for exactly one edge, then is scrambled.
   always @(posedge clk) begin
      if (!sram_csb0) mem[sram_addr0] <= sram_din0;
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
      else            sram_dout1 <= {$urandom, $urandom, $urandom, $urandom};
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle's inputs, checks against the model, updates the model.
   task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd, input logic pr);
      logic pushFire;
      logic popFire;
      push_valid = pv;
      push_data  = pd;
      pop_ready  = pr;
      #1;
      pushFire = pv && push_ready;
      popFire  = pop_valid && pr;
      checkOutput("level", DW'(level), DW'(q.size()));
      checkOutput("level_max", DW'(level <= DEPTH + 2), DW'(1));
      if (q.size() == 0) checkOutput("pop_valid_empty", DW'(pop_valid), DW'(0));
      else if (pop_valid) checkOutput("pop_data", pop_data, q[0]);
      if (q.size() < DEPTH) checkOutput("push_ready_room", DW'(push_ready), DW'(1));
      if (q.size() == DEPTH + 2) checkOutput("push_ready_full", DW'(push_ready), DW'(0));
      checkOutput("csb0", DW'(sram_csb0), DW'(!pushFire));
      if (pushFire) begin
         checkOutput("addr0", DW'(sram_addr0), DW'(wrCnt));
         checkOutput("din0", sram_din0, pd);
         wrCnt = (wrCnt + 1) % DEPTH;
      end
      if (!sram_csb1) begin
         checkOutput("addr1", DW'(sram_addr1), DW'(rdCnt));
         rdCnt = (rdCnt + 1) % DEPTH;
      end
      checkOutput("addr_conflict", DW'(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)), DW'(0));
      if (popFire && q.size() > 0) void'(q.pop_front());
      if (pushFire) q.push_back(pd);
   endtask

   task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr);
      applyStimulus(pv, pd, pr);
      @(negedge clk);
   endtask

   task automatic doReset();
      rstb       = 1'b0;
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      #1;
      checkOutput("rst_push_ready", DW'(push_ready), DW'(0));
      checkOutput("rst_csb0", DW'(sram_csb0), DW'(1));
      checkOutput("rst_csb1", DW'(sram_csb1), DW'(1));
      @(negedge clk);
      rstb = 1'b1;
      q.delete();
      wrCnt = 0;
      rdCnt = 0;
      #1;
      checkOutput("rst_level", DW'(level), DW'(0));
      checkOutput("rst_pop_valid", DW'(pop_valid), DW'(0));
      checkOutput("rst_pop_data", pop_data, DW'(0));
   endtask

   task automatic drainAll();
      int n = 0;
      while ((q.size() > 0 || level != 0) && n < 200) begin
         cycle(1'b0, '0, 1'b1);
         n++;
      end
      if (n >= 200) checkOutput("drain_timeout", DW'(1), DW'(0));
   endtask

   initial begin
      logic [DW-1:0] a5;
      logic [DW-1:0] word;
      int            acc;
      int            gap;
      int            popped;
      logic          seen;
      int            pvPct;
      int            prPct;
      a5 = {16{8'hA5}};

      doReset();

      // Single word: write, read one cycle later, visible two edges after push.
      applyStimulus(1'b1, a5, 1'b0);
      checkOutput("sw_csb0", DW'(sram_csb0), DW'(0));
      checkOutput("sw_addr0", DW'(sram_addr0), DW'(0));
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("sw_csb1", DW'(sram_csb1), DW'(0));
      checkOutput("sw_addr1", DW'(sram_addr1), DW'(0));
      checkOutput("sw_level1", DW'(level), DW'(1));
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("sw_not_yet_valid", DW'(pop_valid), DW'(0));
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("sw_pop_valid", DW'(pop_valid), DW'(1));
      checkOutput("sw_pop_data", pop_data, a5);
      checkOutput("sw_level2", DW'(level), DW'(1));
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("sw_level_after", DW'(level), DW'(0));
      @(negedge clk);

      // Fill with the consumer stalled.
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, DW'(32'h1000 + i), 1'b0);
         if (push_ready) acc++;
         @(negedge clk);
      end
      #1;
      checkOutput("fill_accepted", DW'(acc), DW'(33));
      checkOutput("fill_level", DW'(level), DW'(33));
      checkOutput("fill_push_ready", DW'(push_ready), DW'(0));
      checkOutput("fill_pop_valid", DW'(pop_valid), DW'(1));

      // Drain one from full: read issues same cycle, push_ready next cycle.
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("drain_rd_issue", DW'(sram_csb1), DW'(0));
      @(negedge clk);
      applyStimulus(1'b1, DW'(32'hBEEF), 1'b0);
      checkOutput("drain_push_ready", DW'(push_ready), DW'(1));
      @(negedge clk);
      #1;
      checkOutput("drain_refill_level", DW'(level), DW'(33));
      drainAll();

      // Continuous push and pop across several pointer wraps.
      doReset();
      gap = 0;
      popped = 0;
      seen = 1'b0;
      for (int i = 0; i < 103; i++) begin
         applyStimulus(i < 100, DW'(i), 1'b1);
         if (pop_valid) begin
            seen = 1'b1;
            popped++;
         end else if (seen && popped < 100) begin
            gap++;
         end
         @(negedge clk);
      end
      checkOutput("thru_gaps", DW'(gap), DW'(0));
      checkOutput("thru_popped", DW'(popped), DW'(100));

      // Reset while a read is in flight.
      doReset();
      for (int i = 0; i < 11; i++) cycle(1'b1, DW'(32'h2000 + i), 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("mid_rd_issue", DW'(sram_csb1), DW'(0));
      @(negedge clk);
      #1;
      checkOutput("mid_level", DW'(level), DW'(10));
      doReset();
      word = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, word, 1'b0);
      checkOutput("post_rst_addr0", DW'(sram_addr0), DW'(0));
      @(negedge clk);
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("post_rst_valid", DW'(pop_valid), DW'(1));
      checkOutput("post_rst_data", pop_data, word);
      @(negedge clk);

      // Random traffic with phases biased toward filling, draining and balance.
      for (int i = 0; i < 800; i++) begin
         case ((i / 100) % 4)
            0: begin pvPct = 90; prPct = 20; end
            1: begin pvPct = 20; prPct = 90; end
            2: begin pvPct = 95; prPct = 95; end
            default: begin pvPct = 50; prPct = 50; end
         endcase
         word = {$urandom, $urandom, $urandom, $urandom};
         cycle($urandom_range(0, 99) < pvPct, word, $urandom_range(0, 99) < prPct);
      end
      drainAll();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
